itof: RTL and testbench



---
 rtl/fpu_pkg.sv | 18 +
 rtl/lzc32.sv | 29 ++
 rtl/itof.sv | 114 +++++++++++
 tb/tb_itof.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format widths, exponent bias and the fp32 field layout.
package fpu_pkg;

  localparam int unsigned FP_BIAS   = 127;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned INT_W     = 32;
  localparam int unsigned LZ_W      = 5;
  localparam int unsigned EXP_PRE_W = 9;

  // IEEE-754 single-precision word {sign, exp, frac}
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter.
//   i_a        : operand
//   o_cnt      : number of leading zeros (0..31), 0 when i_a is all zero
//   o_all_zero : i_a == 0
module lzc32
  import fpu_pkg::*;
(
  input  logic [INT_W-1:0] i_a,
  output logic [LZ_W-1:0]  o_cnt,
  output logic             o_all_zero
);

  logic w_found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    o_cnt   = '0;
    w_found = 1'b0;
    for (int i = INT_W - 1; i >= 0; i--) begin
      if (!w_found && i_a[i]) begin
        o_cnt   = LZ_W'(INT_W - 1 - i);
        w_found = 1'b1;
      end
    end
  end

  assign o_all_zero = ~|i_a;

endmodule

// File: rtl/itof.sv
// Three-stage pipelined 32-bit integer to IEEE-754 single converter,
// round-to-nearest-even, valid/ready on both sides.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready/x   : operand handshake (in_ready is combinational)
//   out_valid/out_ready/y : result handshake, y = {sign, exp, frac}
module itof
  import fpu_pkg::*;
#(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] y
);

  // Stage registers
  logic                  r_v1, r_v2, r_v3;
  logic                  r_sign1, r_sign2;
  logic [INT_W-1:0]      r_mag1;
  logic                  r_zero2;
  logic [INT_W-2:0]      r_norm2;
  logic [EXP_PRE_W-1:0]  r_exp2;
  fp32_t                 r_y3;

  // Load enables: a stage loads when it is empty or its content moves on
  logic w_en1, w_en2, w_en3;
  assign w_en3 = !r_v3 || out_ready;
  assign w_en2 = !r_v2 || w_en3;
  assign w_en1 = !r_v1 || w_en2;

  // Stage 1: sign / magnitude (-2^31 maps to 0x8000_0000 as unsigned)
  logic             w_sign1;
  logic [INT_W-1:0] w_mag1;
  assign w_sign1 = SIGNED_IN & x[INT_W-1];
  assign w_mag1  = w_sign1 ? (~x + INT_W'(1)) : x;

  // Stage 2: normalise; hidden bit norm[31] is dropped since it is implied
  logic [LZ_W-1:0]      w_lz;
  logic                 w_all_zero;
  logic [INT_W-2:0]     w_norm2;
  logic [EXP_PRE_W-1:0] w_exp2;

  lzc32 u_lzc (
    .i_a        (r_mag1),
    .o_cnt      (w_lz),
    .o_all_zero (w_all_zero)
  );

  assign w_norm2 = (INT_W-1)'(r_mag1 << w_lz);
  assign w_exp2  = EXP_PRE_W'(FP_BIAS + INT_W - 1) - EXP_PRE_W'(w_lz);

  // Stage 3: round to nearest even and pack
  logic [FP_FRAC_W-1:0] w_frac;
  logic                 w_guard, w_sticky, w_rnd;
  logic [FP_FRAC_W:0]   w_frac_inc;
  fp32_t                w_y3;

  assign w_frac     = r_norm2[INT_W-2 -: FP_FRAC_W];
  assign w_guard    = r_norm2[7];
  assign w_sticky   = |r_norm2[6:0];
  assign w_rnd      = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_inc = {1'b0, w_frac} + (FP_FRAC_W+1)'(w_rnd);

  // Frac carry-out leaves frac all-zero and bumps the exponent
  always_comb begin
    w_y3 = '0;
    if (!r_zero2) begin
      w_y3.sign = r_sign2;
      w_y3.exp  = FP_EXP_W'(r_exp2 + EXP_PRE_W'(w_frac_inc[FP_FRAC_W]));
      w_y3.frac = w_frac_inc[FP_FRAC_W-1:0];
    end
  end

  // Pipeline registers; data loads only when the upstream slot holds a value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_sign1 <= 1'b0;
      r_mag1  <= '0;
      r_sign2 <= 1'b0;
      r_zero2 <= 1'b0;
      r_norm2 <= '0;
      r_exp2  <= '0;
      r_y3    <= '0;
    end else begin
      if (w_en1) r_v1 <= in_valid;
      if (w_en1 && in_valid) begin
        r_sign1 <= w_sign1;
        r_mag1  <= w_mag1;
      end
      if (w_en2) r_v2 <= r_v1;
      if (w_en2 && r_v1) begin
        r_sign2 <= r_sign1;
        r_zero2 <= w_all_zero;
        r_norm2 <= w_norm2;
        r_exp2  <= w_exp2;
      end
      if (w_en3) r_v3 <= r_v2;
      if (w_en3 && r_v2) r_y3 <= w_y3;
    end
  end

  assign in_ready  = w_en1;
  assign out_valid = r_v3;
  assign y         = r_y3;

endmodule

// File: tb/tb_itof.sv
// Self-checking bench for itof: directed latency/rounding cases, backpressure,
// mid-stream reset and a randomized scoreboard run against an arithmetic model.
module tb_itof;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x, y;
  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [31:0] u_x, u_y;

  always #5 clk = ~clk;

  itof #(.SIGNED_IN(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  itof #(.SIGNED_IN(1'b0)) u_dut_u (
    .clk(clk), .rst(rst),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .x(u_x),
    .out_valid(u_out_valid), .out_ready(u_out_ready), .y(u_y)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  int          out_cycles[$];
  int          n_in, n_out, cyc;
  bit          hold;
  logic [31:0] hold_y;

  // Reference: exact integer value rounded to a 24-bit significand, ties to even
  function automatic logic [31:0] ref_conv(logic [31:0] xv, bit signed_in);
    bit                s;
    longint unsigned   mag, q24, rem, den, half;
    int                p;
    s   = signed_in && xv[31];
    mag = s ? (64'd4294967296 - 64'(xv)) : 64'(xv);
    if (mag == 0) return 32'h0;
    p = $clog2(mag + 1) - 1;
    if (p <= 23) begin
      q24 = mag * (longint'(1) << (23 - p));
    end else begin
      den  = longint'(1) << (p - 23);
      q24  = mag / den;
      rem  = mag % den;
      half = den / 2;
      if (rem > half || (rem == half && q24[0])) q24 = q24 + 1;
      if (q24 == 64'd16777216) begin
        q24 = q24 / 2;
        p   = p + 1;
      end
    end
    return {s, 8'(127 + p), 23'(q24)};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of the main DUT with scoreboard and hold-stability checks
  task automatic mon();
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_y", y, hold_y);
    end
    if (in_valid && in_ready) begin
      q.push_back(ref_conv(x, 1'b1));
      n_in++;
    end
    if (out_valid && out_ready) begin
      n_cmp++;
      assert (q.size() > 0) else begin
        n_bad++;
        $error("FAIL spurious_out: observed y=%h with empty queue, expected no output", y);
      end
      if (q.size() > 0) chk("sb_y", y, q.pop_front());
      out_cycles.push_back(cyc);
      n_out++;
    end
    hold   = out_valid && !out_ready;
    hold_y = y;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(bit sel, logic v, logic [31:0] xv);
    if (sel) begin u_in_valid = v; u_x = xv; end
    else     begin in_valid   = v; x   = xv; end
  endtask

  // Single operand, idle pipe: check acceptance, latency and value
  task automatic directed(bit sel, logic [31:0] xv, logic [31:0] ye, string tag);
    drive(sel, 1'b1, xv);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(sel ? u_in_ready : in_ready), 32'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, 32'(sel ? u_out_valid : out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_valid"}, 32'(sel ? u_out_valid : out_valid), 32'd1);
    chk({tag, "_y"}, sel ? u_y : y, ye);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = $urandom_range(0, 32'h0100_0000);
      2:       r = (32'h1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 6)) - 32'd3;
      default: r = 32'h0 - 32'($urandom_range(0, 32'h0400_0000));
    endcase
    return r;
  endfunction

  initial begin
    rst = 1'b1; cyc = 0; hold = 1'b0; hold_y = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b1;
    u_in_valid = 1'b0; u_x = '0; u_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_u_in_ready", 32'(u_in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    directed(1'b0, 32'd1,          32'h3F80_0000, "one");
    directed(1'b0, 32'hFFFF_FFFF,  32'hBF80_0000, "neg_one");
    directed(1'b0, 32'd0,          32'h0000_0000, "zero");
    directed(1'b0, 32'h8000_0000,  32'hCF00_0000, "int_min");
    directed(1'b0, 32'h7FFF_FFFF,  32'h4F00_0000, "int_max");
    directed(1'b0, 32'd16777217,   32'h4B80_0000, "tie_even");
    directed(1'b0, 32'd16777219,   32'h4B80_0002, "tie_odd");
    directed(1'b0, 32'd16777221,   32'h4B80_0002, "tie_even2");
    directed(1'b1, 32'hFFFF_FFFF,  32'h4F80_0000, "u_max");
    directed(1'b1, 32'h8000_0000,  32'h4F00_0000, "u_msb");

    // Backpressure: 6 operands, consumer stalled for 5 cycles
    n_in = 0; n_out = 0; out_cycles.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (n_in < 6); x = 32'(n_in + 1);
      mon();
    end
    chk("bp_accepted", 32'(n_in), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 30 && n_out < 6; k++) begin
      in_valid = (n_in < 6); x = 32'(n_in + 1);
      mon();
    end
    in_valid = 1'b0;
    chk("bp_drained", 32'(n_out), 32'd6);
    for (int i = 1; i < out_cycles.size(); i++)
      chk("bp_nogap", 32'(out_cycles[i] - out_cycles[0]), 32'(i));
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset with three results in flight
    n_in = 0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; x = 32'(100 + k);
      mon();
    end
    in_valid = 1'b0;
    chk("mid_full", 32'(n_in), 32'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y", y, 32'h0);
    q.delete(); hold = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; n_out = 0;
    in_valid = 1'b1; x = 32'd5;
    mon();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && n_out < 1; k++) mon();
    chk("mid_first_out", 32'(n_out), 32'd1);
    chk("mid_queue_empty", 32'(q.size()), 32'd0);

    // Randomized traffic on both sides
    n_in = 0; n_out = 0;
    for (int c = 0; c < 60000 && n_in < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      x         = rand_x();
      out_ready = ($urandom_range(0, 3) != 0);
      mon();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() > 0; c++) mon();
    chk("rand_accepted", 32'(n_in), 32'd10000);
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
